// File: rtl/sram_arb_pkg.sv
// Shared types for the sram-like two-master arbiter: owner ids and arbiter states.
package sram_arb_pkg;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// In-order FIFO of owner ids for accepted-but-unreturned transactions.
module owner_fifo
    import sram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  owner_e                   wdata,
    output owner_e                   rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    owner_e          mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic            do_push;
    logic            do_pop;

    always_comb begin
        full    = (count == (PW+1)'(DEPTH));
        empty   = (count == '0);
        do_pop  = pop & ~empty;
        // a pop frees the slot, so a push into a full FIFO is legal that cycle
        do_push = push & (~full | do_pop);
        rdata   = mem[rptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master (instruction/data) sram-like arbiter onto one in-order slave.
// Optional macro SRAM_ARB_ROUND_ROBIN_EN: round-robin on contention instead of data priority.
module sram_like_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_uncached,
    output logic [31:0] i_rdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,

    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_uncached,
    output logic [31:0] d_rdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_uncached,
    input  logic [31:0] m_rdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,

    output logic        busy
);

    localparam int unsigned CW = $clog2(OUTSTANDING) + 1;

    arb_state_e      state;
    arb_state_e      state_next;
    owner_e          idle_sel;
    owner_e          sel;
    owner_e          head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            sel_req;
    logic            accept;
    logic            data_pop;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    owner_e last_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= OWNER_I;
        end else if (accept) begin
            last_grant <= sel;
        end
    end

    always_comb begin
        if (i_req && d_req) begin
            idle_sel = (last_grant == OWNER_I) ? OWNER_D : OWNER_I;
        end else if (d_req) begin
            idle_sel = OWNER_D;
        end else begin
            idle_sel = OWNER_I;
        end
    end
`else
    always_comb begin
        idle_sel = d_req ? OWNER_D : OWNER_I;
    end
`endif

    // Selection is split from next-state logic so m_req never loops back into sel.
    always_comb begin
        sel = idle_sel;
        case (state)
            LOCK_I:  sel = OWNER_I;
            LOCK_D:  sel = OWNER_D;
            default: sel = idle_sel;
        endcase
    end

    always_comb begin
        sel_req    = (sel == OWNER_D) ? d_req : i_req;
        // full is registered, so a same-cycle m_data_ok cannot unblock m_req
        m_req      = ~rst & sel_req & ~fifo_full;
        m_wr       = (sel == OWNER_D) ? d_wr       : i_wr;
        m_size     = (sel == OWNER_D) ? d_size     : i_size;
        m_addr     = (sel == OWNER_D) ? d_addr     : i_addr;
        m_wdata    = (sel == OWNER_D) ? d_wdata    : i_wdata;
        m_uncached = (sel == OWNER_D) ? d_uncached : i_uncached;

        accept     = m_req & m_addr_ok;
        i_addr_ok  = accept & (sel == OWNER_I);
        d_addr_ok  = accept & (sel == OWNER_D);

        data_pop   = ~rst & m_data_ok & ~fifo_empty;
        i_data_ok  = data_pop & (head == OWNER_I);
        d_data_ok  = data_pop & (head == OWNER_D);

        i_rdata    = m_rdata;
        d_rdata    = m_rdata;
        busy       = (fifo_count != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (m_req && !m_addr_ok) begin
                    state_next = (idle_sel == OWNER_D) ? LOCK_D : LOCK_I;
                end
            end
            LOCK_I, LOCK_D: begin
                if (accept) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (data_pop),
        .wdata (sel),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized scoreboard bench for sram_like_arbiter against a transaction-level model.
// Follows SRAM_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_sram_like_arbiter;

    localparam int unsigned OUT = 4;

    logic        clk;
    logic        rst;
    logic        i_req, i_wr, i_uncached;
    logic [1:0]  i_size;
    logic [31:0] i_addr, i_wdata, i_rdata;
    logic        i_addr_ok, i_data_ok;
    logic        d_req, d_wr, d_uncached;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_addr_ok, d_data_ok;
    logic        m_req, m_wr, m_uncached;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_addr_ok, m_data_ok;
    logic        busy;

    sram_like_arbiter #(.OUTSTANDING(OUT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_uncached(i_uncached), .i_rdata(i_rdata), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_uncached(d_uncached), .d_rdata(d_rdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_uncached(m_uncached), .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        owner;
        logic [31:0] rdata;
    } exp_t;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    exp_t        exp_q[$];
    logic [31:0] slave_q[$];
    int unsigned out_cnt = 0;
    bit          i_pend = 0, d_pend = 0;
    bit          lock_v = 0;
    logic        lock_o = 1'b0;
    logic        last_o = 1'b0;

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every routed data_ok pops the next expected return.
    always @(negedge clk) begin
        if (i_data_ok || d_data_ok) begin
            exp_t e;
            chk("data_ok_onehot", 68'(i_data_ok & d_data_ok), 68'd0);
            chk("data_ok_expected", 68'(exp_q.size() != 0), 68'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("data_ok_owner", 68'(d_data_ok), 68'(e.owner));
                chk("rdata", 68'(d_data_ok ? d_rdata : i_rdata), 68'(e.rdata));
            end
        end
    end

    task automatic evaluate();
        logic        sel, sreq, exp_mreq;
        logic [67:0] fields;
        bit          dok_exp;
        logic [31:0] rd;
        if (rst) begin
            chk("rst_m_req", 68'(m_req), 68'd0);
            chk("rst_addr_ok", 68'({i_addr_ok, d_addr_ok}), 68'd0);
            chk("rst_data_ok", 68'({i_data_ok, d_data_ok}), 68'd0);
            out_cnt = 0;
            slave_q.delete();
            exp_q.delete();
            lock_v = 0;
            last_o = 1'b0;
            return;
        end
        chk("busy", 68'(busy), 68'(out_cnt != 0));
        chk("rdata_fanout", 68'({i_rdata, d_rdata}), 68'({m_rdata, m_rdata}));
        if (lock_v) sel = lock_o;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        else if (i_req && d_req) sel = ~last_o;
`endif
        else sel = d_req;
        sreq     = sel ? d_req : i_req;
        exp_mreq = sreq && (out_cnt < OUT);
        chk("m_req", 68'(m_req), 68'(exp_mreq));
        if (exp_mreq) begin
            fields = sel ? {d_wr, d_size, d_addr, d_wdata, d_uncached}
                         : {i_wr, i_size, i_addr, i_wdata, i_uncached};
            chk("m_fields", {m_wr, m_size, m_addr, m_wdata, m_uncached}, fields);
        end
        chk("i_addr_ok", 68'(i_addr_ok), 68'(exp_mreq & m_addr_ok & ~sel));
        chk("d_addr_ok", 68'(d_addr_ok), 68'(exp_mreq & m_addr_ok & sel));
        dok_exp = m_data_ok && (out_cnt > 0);
        chk("data_ok_present", 68'(i_data_ok | d_data_ok), 68'(dok_exp));
        if (dok_exp) begin
            void'(slave_q.pop_front());
            out_cnt--;
        end
        if (exp_mreq && m_addr_ok) begin
            rd = $urandom;
            slave_q.push_back(rd);
            exp_q.push_back('{owner: sel, rdata: rd});
            out_cnt++;
            lock_v = 0;
            last_o = sel;
            if (sel) d_pend = 0; else i_pend = 0;
        end else if (exp_mreq) begin
            lock_v = 1;
            lock_o = sel;
        end
    endtask

    task automatic cycle(input int unsigned pi, input int unsigned pd, input int unsigned paok,
                         input int unsigned pdok, input int unsigned pstray, input bit r);
        @(posedge clk);
        #1;
        rst = r;
        if (!i_pend && $urandom_range(99) < pi) begin
            i_pend = 1;
            i_wr = 1'($urandom); i_size = 2'($urandom); i_addr = $urandom;
            i_wdata = $urandom; i_uncached = 1'($urandom);
        end
        if (!d_pend && $urandom_range(99) < pd) begin
            d_pend = 1;
            d_wr = 1'($urandom); d_size = 2'($urandom); d_addr = $urandom;
            d_wdata = $urandom; d_uncached = 1'($urandom);
        end
        i_req = i_pend;
        d_req = d_pend;
        m_addr_ok = ($urandom_range(99) < paok);
        if (out_cnt > 0 && $urandom_range(99) < pdok) begin
            m_data_ok = 1'b1;
            m_rdata   = slave_q[0];
        end else if (out_cnt == 0 && $urandom_range(99) < pstray) begin
            m_data_ok = 1'b1;
            m_rdata   = $urandom;
        end else begin
            m_data_ok = 1'b0;
            m_rdata   = $urandom;
        end
        @(negedge clk);
        evaluate();
    endtask

    initial begin
        rst = 1'b1;
        {i_req, i_wr, i_size, i_addr, i_wdata, i_uncached} = '0;
        {d_req, d_wr, d_size, d_addr, d_wdata, d_uncached} = '0;
        {m_rdata, m_addr_ok, m_data_ok} = '0;

        // reset with masters requesting
        for (int n = 0; n < 3; n++) cycle(100, 100, 100, 0, 0, 1'b1);
        // instruction master alone, immediate accept and return
        for (int n = 0; n < 30; n++) cycle(100, 0, 100, 100, 0, 1'b0);
        // contention, prompt slave
        for (int n = 0; n < 60; n++) cycle(100, 50, 100, 50, 0, 1'b0);
        // slow address acceptance exercises locking
        for (int n = 0; n < 150; n++) cycle(60, 60, 25, 50, 0, 1'b0);
        // fill the owner FIFO, then trickle returns while full
        for (int n = 0; n < 20; n++) cycle(100, 100, 100, 0, 0, 1'b0);
        for (int n = 0; n < 40; n++) cycle(100, 100, 100, 30, 0, 1'b0);
        // reset with outstanding entries, then stray returns
        for (int n = 0; n < 10; n++) cycle(0, 0, 100, 100, 0, 1'b0);
        for (int n = 0; n < 2; n++) cycle(100, 0, 100, 0, 0, 1'b0);
        cycle(0, 0, 0, 0, 0, 1'b1);
        for (int n = 0; n < 10; n++) cycle(0, 0, 0, 0, 80, 1'b0);
        // mixed random traffic with occasional stray data_ok and resets
        for (int n = 0; n < 1500; n++)
            cycle($urandom_range(100), $urandom_range(100), $urandom_range(100),
                  $urandom_range(100), 20, ($urandom_range(199) == 0));

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 SHALL have parameter OUTSTANDING, default 4, meaning the maximum number of accepted-but-unreturned transactions (power of 2, 2..8).
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port rst, input, 1, reset (synchronous, active-high).
REQ-004 SHALL have ports i_req/i_wr/i_size/i_addr/i_wdata/i_uncached, input, 1/1/2/32/32/1, instruction-master sram-like request.
REQ-005 SHALL have ports i_rdata/i_addr_ok/i_data_ok, output, 32/1/1, instruction-master responses.
REQ-006 SHALL have ports d_req/d_wr/d_size/d_addr/d_wdata/d_uncached, input, 1/1/2/32/32/1, data-master sram-like request.
REQ-007 SHALL have ports d_rdata/d_addr_ok/d_data_ok, output, 32/1/1, data-master responses.
REQ-008 SHALL have ports m_req/m_wr/m_size/m_addr/m_wdata/m_uncached, output, 1/1/2/32/32/1, shared slave request.
REQ-009 SHALL have ports m_rdata/m_addr_ok/m_data_ok, input, 32/1/1, shared slave responses (returned in acceptance order).
REQ-010 SHALL have port busy, output, 1, high while any transaction is outstanding.

Function
REQ-011 SHALL present exactly one master's request fields on m_* per cycle; m_req = selected master's req AND owner FIFO not full.
REQ-012 SHALL use arbiter states IDLE, LOCK_I, LOCK_D: IDLE selects combinationally; if m_req high and m_addr_ok low, go to LOCK_<selected> and hold that selection until m_addr_ok, then return to IDLE.
REQ-013 SHALL, in IDLE with both requests, select d (data priority) unless configured otherwise (REQ-025).
REQ-014 SHALL route m_addr_ok only to the selected master's *_addr_ok; the other master's addr_ok is 0.
REQ-015 SHALL push the owner id (0=i, 1=d) into an in-order owner FIFO of depth OUTSTANDING on m_req & m_addr_ok.
REQ-016 SHALL route m_data_ok to the FIFO-head owner's *_data_ok and pop on m_data_ok; m_rdata is driven to both i_rdata and d_rdata unqualified.
REQ-017 SHALL allow push and pop in the same cycle, including when full (count unchanged, no lost entry).
REQ-018 SHALL deassert m_req while the FIFO is full and no pop occurs that cycle; full with a same-cycle pop SHALL still block (no combinational path m_data_ok -> m_req).
REQ-019 SHALL ignore m_data_ok when the FIFO is empty (no pop, no data_ok to either master).
REQ-020 SHALL wrap FIFO pointers modulo OUTSTANDING; count is clog2(OUTSTANDING)+1 bits.
REQ-021 SHALL drive busy = (count != 0).

Reset
REQ-022 SHALL on rst set state IDLE, FIFO count/pointers 0, busy 0, m_req 0, i_addr_ok/d_addr_ok/i_data_ok/d_data_ok 0.
REQ-023 SHALL, on reset mid-transaction, discard outstanding entries; a later stray m_data_ok is dropped per REQ-019.
REQ-024 SHALL keep m_req 0 during rst regardless of master requests.

Configuration
REQ-025 SHALL support macro SRAM_ARB_ROUND_ROBIN_EN: defined -> on contention in IDLE, grant the master not granted last (1-bit last-grant register, reset to i, so d wins first contention); undefined -> fixed data priority, no last-grant register.

Structure
REQ-026 SHALL place owner-id enum (OWNER_I, OWNER_D) and arbiter state enum in shared package sram_arb_pkg.
REQ-027 SHALL implement the owner FIFO as sub-module owner_fifo (1-bit data, parameter DEPTH).

Verification
REQ-028 Only i_req=1, slave addr_ok same cycle, data_ok 1 cycle later with 0x3C000001 -> i_addr_ok then i_data_ok, i_rdata=0x3C000001, d_* 0.
REQ-029 i_req and d_req together, fixed priority -> d granted first (m_addr=d_addr), i granted next cycle; data_ok returns routed d then i.
REQ-030 i_req, m_addr_ok low 3 cycles, d_req rises in cycle 2 -> m_addr stays i_addr until addr_ok (LOCK_I), then d served.
REQ-031 OUTSTANDING=4, 4 accepts with no data_ok -> m_req 0 on 5th request; one m_data_ok -> next cycle 5th accepted; busy stays 1.
REQ-032 rst asserted with 2 outstanding, then m_data_ok pulse -> no i_data_ok/d_data_ok, busy 0.
REQ-033 With SRAM_ARB_ROUND_ROBIN_EN, both requesting continuously -> grants alternate d,i,d,i.
